// File: rtl/i2s_rx_oversampled_pkg.sv
// Shared audio receive definitions: default word sizes and the receiver lock/slot state.
package i2s_rx_oversampled_pkg;
  localparam int BITSIZE_DEF     = 24;
  localparam int MAX_BITS_DEF    = 32;
  localparam int SYNC_STAGES_DEF = 2;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    IN_LEFT  = 2'd1,
    IN_RIGHT = 2'd2
  } rx_state_t;
endpackage

// File: rtl/i2s_rx_oversampled_sync_edge_detect.sv
// Multi-flop synchronizer for an asynchronous pin, with optional rising-edge pulse.
module sync_edge_detect
  import i2s_rx_oversampled_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter bit EDGE_EN     = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise
);
  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], din};
  end

  assign level = sync_q[SYNC_STAGES-1];

  generate
    if (EDGE_EN) begin : g_edge
      logic prev_q;
      always_ff @(posedge clk) begin
        if (reset) prev_q <= 1'b0;
        else       prev_q <= level;
      end
      assign rise = level & ~prev_q;
    end else begin : g_level_only
      assign rise = 1'b0;
    end
  endgenerate
endmodule

// File: rtl/i2s_rx_oversampled.sv
// Oversampling I2S receiver: deserializes codec ADC words into stereo frames on clk.
// Optional framing check enabled by defining I2S_RX_FRAMING_CHECK_EN.
module i2s_rx_oversampled
  import i2s_rx_oversampled_pkg::*;
#(
  parameter int BITSIZE     = BITSIZE_DEF,
  parameter int MAX_BITS    = MAX_BITS_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               bclk,
  input  logic               lrclk,
  input  logic               sdata,
  output logic [BITSIZE-1:0] left_chan,
  output logic [BITSIZE-1:0] right_chan,
  output logic               frame_valid,
  output logic               framing_error,
  output logic [15:0]        err_count
);
  localparam int CW = $clog2(MAX_BITS + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_BITS);
  localparam logic [CW-1:0] CNT_WORD = CW'(BITSIZE);

  logic bclk_s, bclk_rise, lr_s, sd_s;
  logic lr_rise_unused, bclk_level_unused, sd_rise_unused;

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES), .EDGE_EN(1'b1)) u_bclk_sync (
    .clk(clk), .reset(reset), .din(bclk), .level(bclk_s), .rise(bclk_rise));
  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES), .EDGE_EN(1'b0)) u_lr_sync (
    .clk(clk), .reset(reset), .din(lrclk), .level(lr_s), .rise(lr_rise_unused));
  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES), .EDGE_EN(1'b0)) u_sd_sync (
    .clk(clk), .reset(reset), .din(sdata), .level(sd_s), .rise(sd_rise_unused));

  assign bclk_level_unused = bclk_s;

  rx_state_t          state, state_n;
  logic [BITSIZE-1:0] shreg, shreg_n, stage, stage_n, left_n, right_n;
  logic [BITSIZE-1:0] word, justified;
  logic [CW-1:0]      count, count_n, cnt_inc, fill;
  logic               lr_prev, lr_prev_n, have_left, have_left_n, fv_n, close;

  // Word/count as they stand after taking the bit sampled in this rise event.
  always_comb begin
    word      = (count < CNT_WORD) ? {shreg[BITSIZE-2:0], sd_s} : shreg;
    cnt_inc   = (count == CNT_MAX) ? count : count + CW'(1);
    fill      = (cnt_inc < CNT_WORD) ? CNT_WORD - cnt_inc : '0;
    justified = word << fill;
    close     = bclk_rise && (lr_s != lr_prev);
  end

  always_comb begin
    state_n     = state;
    shreg_n     = shreg;
    count_n     = count;
    lr_prev_n   = lr_prev;
    stage_n     = stage;
    have_left_n = have_left;
    left_n      = left_chan;
    right_n     = right_chan;
    fv_n        = 1'b0;
    if (bclk_rise) begin
      if (!close) begin
        shreg_n = word;
        count_n = cnt_inc;
      end else begin
        shreg_n   = '0;
        count_n   = '0;
        lr_prev_n = lr_s;
        case (state)
          UNLOCKED: state_n = lr_s ? IN_RIGHT : IN_LEFT;
          IN_LEFT: begin
            stage_n     = justified;
            have_left_n = 1'b1;
            state_n     = IN_RIGHT;
          end
          IN_RIGHT: begin
            if (have_left) begin
              left_n  = stage;
              right_n = justified;
              fv_n    = 1'b1;
            end
            have_left_n = 1'b0;
            state_n     = IN_LEFT;
          end
          default: state_n = UNLOCKED;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= UNLOCKED;
      shreg       <= '0;
      count       <= '0;
      lr_prev     <= 1'b0;
      stage       <= '0;
      have_left   <= 1'b0;
      left_chan   <= '0;
      right_chan  <= '0;
      frame_valid <= 1'b0;
    end else begin
      state       <= state_n;
      shreg       <= shreg_n;
      count       <= count_n;
      lr_prev     <= lr_prev_n;
      stage       <= stage_n;
      have_left   <= have_left_n;
      left_chan   <= left_n;
      right_chan  <= right_n;
      frame_valid <= fv_n;
    end
  end

`ifdef I2S_RX_FRAMING_CHECK_EN
  logic        fe_n;
  logic [15:0] errc_n;

  // A well-formed slot closes with exactly MAX_BITS clocks, delay bit included.
  always_comb begin
    fe_n   = 1'b0;
    errc_n = err_count;
    if (close && state != UNLOCKED && cnt_inc != CNT_MAX) begin
      fe_n = 1'b1;
      if (err_count != 16'hFFFF) errc_n = err_count + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      framing_error <= 1'b0;
      err_count     <= '0;
    end else begin
      framing_error <= fe_n;
      err_count     <= errc_n;
    end
  end
`else
  assign framing_error = 1'b0;
  assign err_count     = '0;
`endif
endmodule

// File: tb/tb_i2s_rx_oversampled.sv
// Scoreboard bench: drives I2S slots, predicts stereo frames at word level, checks on frame_valid.
module tb_i2s_rx_oversampled;
  logic        clk = 1'b0;
  logic        reset, bclk, lrclk, sdata;
  logic [23:0] left_chan, right_chan;
  logic        frame_valid, framing_error;
  logic [15:0] err_count;

  i2s_rx_oversampled dut (
    .clk(clk), .reset(reset), .bclk(bclk), .lrclk(lrclk), .sdata(sdata),
    .left_chan(left_chan), .right_chan(right_chan), .frame_valid(frame_valid),
    .framing_error(framing_error), .err_count(err_count));

  always #10 clk = ~clk;

  typedef struct { logic [23:0] l; logic [23:0] r; } frame_t;
  frame_t sb[$];

  int n_pass = 0, n_total = 0;
  int cyc, last_fv, fe_total, fe_base, exp_err;
  bit chk_period = 1'b0;

  // Word-level reference: what the receiver should have seen per slot.
  logic        lr_ref, carry = 1'b0;
  bit          locked, pend_valid;
  logic [23:0] pend_left;
  logic [31:0] cur_data;
  int          cur_n;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [23:0] justify(input logic [31:0] d, input int n);
    logic [31:0] t;
    if (n >= 24) t = d >> (n - 24);
    else         t = d << (24 - n);
    return t[23:0];
  endfunction

  task automatic close_word();
    if (!locked) locked = 1'b1;
    else begin
      if (cur_n != 32) exp_err++;
      if (lr_ref == 1'b0) begin
        pend_left  = justify(cur_data, cur_n);
        pend_valid = 1'b1;
      end else begin
        if (pend_valid) sb.push_back('{l: pend_left, r: justify(cur_data, cur_n)});
        pend_valid = 1'b0;
      end
    end
  endtask

  task automatic model_reset();
    locked     = 1'b0;
    pend_valid = 1'b0;
    lr_ref     = 1'b0;
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One slot of n BCLK periods; first period carries the previous slot's LSB.
  task automatic slot(input logic lr, input logic [31:0] d, input int n, input int half,
                      input int rst_at);
    for (int i = 0; i < n; i++) begin
      bclk  = 1'b0;
      lrclk = lr;
      sdata = (i == 0) ? carry : d[n-i];
      if (i == 0) begin
        if (lr != lr_ref) begin
          close_word();
          lr_ref = lr;
        end
        cur_data = d;
        cur_n    = n;
      end
      if (i == rst_at) begin
        reset = 1'b1;
        wait_clk(1);
        reset = 1'b0;
        check("rst_left_zero", 32'(left_chan), 32'h0);
        check("rst_right_zero", 32'(right_chan), 32'h0);
        check("rst_fv_zero", 32'(frame_valid), 32'h0);
        model_reset();
        if (lr != lr_ref) begin
          close_word();
          lr_ref = lr;
        end
        wait_clk(half - 1);
      end else wait_clk(half);
      bclk = 1'b1;
      wait_clk(half);
    end
    carry = d[0];
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a frame.
  initial begin
    frame_t e;
    cyc = 0; last_fv = -1; fe_total = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (framing_error) fe_total++;
      if (frame_valid) begin
        if (sb.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_frame_valid: got valid at cycle %0d, expected none", cyc);
        end else begin
          e = sb.pop_front();
          check("left_chan", 32'(left_chan), 32'(e.l));
          check("right_chan", 32'(right_chan), 32'(e.r));
        end
        if (chk_period && last_fv >= 0) check("fv_period", 32'(cyc - last_fv), 32'd1024);
        last_fv = cyc;
      end
    end
  end

  initial begin
    logic [31:0] r;
    reset = 1'b1; bclk = 1'b0; lrclk = 1'b0; sdata = 1'b0;
    exp_err = 0;
    model_reset();
    wait_clk(4);
    check("reset_left", 32'(left_chan), 32'h0);
    check("reset_right", 32'(right_chan), 32'h0);
    check("reset_fv", 32'(frame_valid), 32'h0);
    check("reset_fe", 32'(framing_error), 32'h0);
    check("reset_errc", 32'(err_count), 32'h0);
    reset = 1'b0;
    wait_clk(2);

    // Fixed pattern, BCLK = clk/16, 32-bit slots.
    chk_period = 1'b1;
    for (int f = 0; f < 7; f++) begin
      slot(1'b0, {24'hA5A5A5, 8'h00}, 32, 8, -1);
      slot(1'b1, {24'h5A5A5A, 8'h00}, 32, 8, -1);
    end
    chk_period = 1'b0;

    // Reset released in the middle of a right slot.
    slot(1'b0, $urandom, 32, 8, -1);
    slot(1'b1, $urandom, 32, 8, 10);
    for (int f = 0; f < 3; f++) begin
      slot(1'b0, $urandom, 32, 8, -1);
      slot(1'b1, $urandom, 32, 8, -1);
    end

    // 16-bit slots, BCLK = clk/32.
    for (int f = 0; f < 4; f++) begin
      slot(1'b0, 32'h0000_8001, 16, 16, -1);
      slot(1'b1, 32'h0000_7FFF, 16, 16, -1);
    end

    // One-clk reset inside a left slot.
    slot(1'b0, $urandom, 32, 8, -1);
    slot(1'b1, $urandom, 32, 8, -1);
    slot(1'b0, $urandom, 32, 8, 12);
    slot(1'b1, $urandom, 32, 8, -1);
    for (int f = 0; f < 2; f++) begin
      slot(1'b0, $urandom, 32, 8, -1);
      slot(1'b1, $urandom, 32, 8, -1);
    end

    // Fastest BCLK (2 clk high/low), random data.
    for (int f = 0; f < 20; f++) begin
      slot(1'b0, $urandom, 32, 2, -1);
      slot(1'b1, $urandom, 32, 2, -1);
    end

    // Clean restart, then one short 20-bit slot among 32-bit slots.
    bclk = 1'b0;
    reset = 1'b1;
    wait_clk(2);
    reset = 1'b0;
    model_reset();
    exp_err = 0;
    fe_base = fe_total;
    wait_clk(4);
    slot(1'b0, $urandom, 32, 8, -1);
    slot(1'b1, $urandom, 32, 8, -1);
    slot(1'b0, $urandom, 32, 8, -1);
    r = $urandom;
    slot(1'b1, {12'h0, r[19:0]}, 20, 8, -1);
    slot(1'b0, $urandom, 32, 8, -1);
    slot(1'b1, $urandom, 32, 8, -1);
    slot(1'b0, $urandom, 32, 8, -1);
    wait_clk(200);

    check("sb_drained", 32'(sb.size()), 32'h0);
`ifdef I2S_RX_FRAMING_CHECK_EN
    check("err_count", 32'(err_count), 32'(exp_err));
    check("err_count_one", 32'(err_count), 32'd1);
    check("fe_pulses", 32'(fe_total - fe_base), 32'(exp_err));
`else
    check("err_count_off", 32'(err_count), 32'h0);
    check("fe_pulses_off", 32'(fe_total), 32'h0);
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
